// File: rtl/poly_fir_rx_decimator_if.sv
// rtl/poly_fir_rx_decimator_if.sv - sample/strobe bundle for the RX matched-filter decimator
//
// Purpose: groups the sample input handshake and the decimated output strobe.
// Signals:
//   i_en     global enable; 0 freezes the filter
//   i_valid  input sample qualifier
//   i_data   signed input sample at 4x symbol rate
//   i_phase  decimation phase select, 0..3
//   o_data   signed filtered, decimated soft sample
//   o_bit    hard decision, 1 when the filtered sum is negative
//   o_valid  one-cycle strobe qualifying o_data/o_bit
// Modports: master drives samples and reads results; slave is the filter side.
interface poly_fir_rx_decimator_if #(
   parameter int NB_INPUT  = 8,
   parameter int NB_OUTPUT = 8
);
   logic                        i_en;
   logic                        i_valid;
   logic signed [NB_INPUT-1:0]  i_data;
   logic [1:0]                  i_phase;
   logic signed [NB_OUTPUT-1:0] o_data;
   logic                        o_bit;
   logic                        o_valid;

   modport master (
      output i_en, i_valid, i_data, i_phase,
      input  o_data, o_bit, o_valid
   );

   modport slave (
      input  i_en, i_valid, i_data, i_phase,
      output o_data, o_bit, o_valid
   );
endinterface

// File: rtl/poly_fir_rx_decimator.sv
// rtl/poly_fir_rx_decimator.sv - 24-tap matched filter with decimate-by-4 at a selectable phase
//
// Purpose: filters 4x-rate signed samples with the fixed 24-tap shaping response
// and emits one quantised soft sample plus a hard bit per symbol.
// Ports:
//   clk    system clock
//   i_rst  synchronous active-high reset; wins over enable and valid
//   bus    poly_fir_rx_decimator_if slave: i_en/i_valid/i_data/i_phase in,
//          o_data/o_bit/o_valid out
module poly_fir_rx_decimator #(
   parameter int NB_INPUT   = 8,
   parameter int NBF_INPUT  = 7,
   parameter int NB_COEFF   = 8,
   parameter int NBF_COEFF  = 7,
   parameter int NB_OUTPUT  = 8,
   parameter int NBF_OUTPUT = 7
) (
   input logic                    clk,
   input logic                    i_rst,
   poly_fir_rx_decimator_if.slave bus
);
   localparam int N_TAPS = 24;
   localparam int PROD_W = NB_INPUT + NB_COEFF;
   localparam int ACC_W  = PROD_W + 5;
   localparam int SHIFT  = NBF_INPUT + NBF_COEFF - NBF_OUTPUT;
   localparam int Q_W    = ACC_W - SHIFT;

   localparam int COEFF_INT [N_TAPS] = '{
       0,   2,   2,   0,  -8, -16, -16,  -1,
      33,  76, 113, 127, 113,  76,  33,   0,
     -16, -16,  -8,  -1,   2,   2,   0,   0
   };

   // Saturation bounds expressed at the width of the truncated sum.
   localparam logic signed [Q_W-1:0] Q_MAX = {{(Q_W-NB_OUTPUT+1){1'b0}}, {(NB_OUTPUT-1){1'b1}}};
   localparam logic signed [Q_W-1:0] Q_MIN = {{(Q_W-NB_OUTPUT+1){1'b1}}, {(NB_OUTPUT-1){1'b0}}};

   logic signed [NB_INPUT-1:0]  x [N_TAPS-1];
   logic signed [NB_INPUT-1:0]  taps [N_TAPS];
   logic signed [NB_COEFF-1:0]  coef;
   logic signed [PROD_W-1:0]    prod;
   logic signed [ACC_W-1:0]     acc;
   logic signed [Q_W-1:0]       q;
   logic signed [NB_OUTPUT-1:0] sat;
   logic [1:0]                  cnt;
   logic                        accept;

   assign accept = bus.i_en && bus.i_valid;

   // Tap 0 is the incoming sample so the decision uses it on the same edge.
   always_comb begin
      taps[0] = bus.i_data;
      for (int k = 1; k < N_TAPS; k++) begin
         taps[k] = x[k-1];
      end
   end

   always_comb begin
      acc  = '0;
      coef = '0;
      prod = '0;
      for (int k = 0; k < N_TAPS; k++) begin
         coef = NB_COEFF'(COEFF_INT[k]);
         prod = taps[k] * coef;
         acc  = acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
      end
   end

   // Truncate (floor) the fractional excess, then clamp to the output range.
   always_comb begin
      q = acc[ACC_W-1:SHIFT];
      if (q > Q_MAX) begin
         sat = {1'b0, {(NB_OUTPUT-1){1'b1}}};
      end else if (q < Q_MIN) begin
         sat = {1'b1, {(NB_OUTPUT-1){1'b0}}};
      end else begin
         sat = q[NB_OUTPUT-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (i_rst) begin
         for (int k = 0; k < N_TAPS-1; k++) begin
            x[k] <= '0;
         end
         cnt         <= 2'd0;
         bus.o_data  <= '0;
         bus.o_bit   <= 1'b0;
         bus.o_valid <= 1'b0;
      end else begin
         bus.o_valid <= 1'b0;
         if (accept) begin
            x[0] <= bus.i_data;
            for (int k = 1; k < N_TAPS-1; k++) begin
               x[k] <= x[k-1];
            end
            cnt <= cnt + 2'd1;
            // Phase compared against the count before this accept's increment.
            if (cnt == bus.i_phase) begin
               bus.o_data  <= sat;
               bus.o_bit   <= acc[ACC_W-1];
               bus.o_valid <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_poly_fir_rx_decimator.sv
// tb/tb_poly_fir_rx_decimator.sv - self-checking bench for poly_fir_rx_decimator
module tb_poly_fir_rx_decimator;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   poly_fir_rx_decimator_if #(.NB_INPUT(8), .NB_OUTPUT(8)) bus ();

   poly_fir_rx_decimator dut (
      .clk   (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   int coef [24] = '{0, 2, 2, 0, -8, -16, -16, -1,
                     33, 76, 113, 127, 113, 76, 33, 0,
                     -16, -16, -8, -1, 2, 2, 0, 0};

   // Reference model: history of accepted samples and accept count mod 4.
   int hist [23];
   int acc_count;
   int m_valid, m_data, m_bit;
   bit chk_on = 1'b0;
   int got [$];
   int n_cmp = 0;
   int n_err = 0;

   function automatic void chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endfunction

   function automatic int clamp8(input int v);
      if (v > 127) return 127;
      if (v < -128) return -128;
      return v;
   endfunction

   task automatic model(input bit r, input bit en, input bit v, input int d, input int ph);
      int sum;
      byte ds;
      if (r) begin
         foreach (hist[k]) hist[k] = 0;
         acc_count = 0;
         m_valid = 0; m_data = 0; m_bit = 0;
         return;
      end
      m_valid = 0;
      if (en && v) begin
         ds = byte'(d);
         sum = coef[0] * int'(ds);
         for (int k = 1; k < 24; k++) sum += coef[k] * hist[k-1];
         if (acc_count % 4 == ph) begin
            m_data  = clamp8(sum >>> 7);
            m_bit   = (sum < 0) ? 1 : 0;
            m_valid = 1;
         end
         for (int k = 22; k > 0; k--) hist[k] = hist[k-1];
         hist[0] = int'(ds);
         acc_count++;
      end
   endtask

   task automatic step(input bit r, input bit en, input bit v, input int d, input int ph);
      @(negedge clk);
      rst         = r;
      bus.i_en    = en;
      bus.i_valid = v;
      bus.i_data  = d[7:0];
      bus.i_phase = ph[1:0];
      model(r, en, v, d, ph);
   endtask

   task automatic settle();
      @(posedge clk);
      #3;
   endtask

   task automatic check_seq(input string nm, input int exp[$]);
      chk({nm, "_count"}, got.size(), exp.size());
      for (int i = 0; i < exp.size() && i < got.size(); i++)
         chk($sformatf("%s[%0d]", nm, i), got[i], exp[i]);
   endtask

   always @(posedge clk) begin
      #2;
      if (chk_on) begin
         chk("o_valid", int'(bus.o_valid), m_valid);
         chk("o_data", int'(bus.o_data), m_data);
         chk("o_bit", int'(bus.o_bit), m_bit);
         if (bus.o_valid) got.push_back(int'(bus.o_data));
      end
   end

   int e_ph0 [$] = '{0, -8, 32, 112, -16, 1, 0};
   int e_ph2 [$] = '{1, -16, 112, 32, -8, 0};

   initial begin
      int accepts;
      bit v;
      int ph;
      bus.i_en = 1'b0; bus.i_valid = 1'b0; bus.i_data = '0; bus.i_phase = '0;

      // Reset with random inputs on the bus.
      step(1, $urandom_range(1), $urandom_range(1), $urandom, $urandom_range(3));
      chk_on = 1'b1;
      step(1, $urandom_range(1), $urandom_range(1), $urandom, $urandom_range(3));
      settle();
      chk("rst_o_data", int'(bus.o_data), 0);
      chk("rst_o_valid", int'(bus.o_valid), 0);

      // Impulse, phase 0.
      got.delete();
      step(0, 1, 1, 127, 0);
      for (int i = 0; i < 27; i++) step(0, 1, 1, 0, 0);
      settle();
      check_seq("impulse_ph0", e_ph0);

      // Impulse, phase 2.
      step(1, 0, 0, 0, 2);
      got.delete();
      step(0, 1, 1, 127, 2);
      for (int i = 0; i < 23; i++) step(0, 1, 1, 0, 2);
      settle();
      check_seq("impulse_ph2", e_ph2);

      // Saturation both ways.
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 40; i++) step(0, 1, 1, 127, 0);
      settle();
      chk("sat_pos_data", int'(bus.o_data), 127);
      chk("sat_pos_bit", int'(bus.o_bit), 0);
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 40; i++) step(0, 1, 1, -128, 0);
      settle();
      chk("sat_neg_data", int'(bus.o_data), -128);
      chk("sat_neg_bit", int'(bus.o_bit), 1);

      // Stalls: random valid gaps plus a 5-cycle enable freeze mid-symbol.
      step(1, 0, 0, 0, 0);
      got.delete();
      accepts = 0;
      while (accepts < 28) begin
         if (accepts == 6) begin
            for (int i = 0; i < 5; i++) step(0, 0, $urandom_range(1), $urandom, 0);
            accepts++;
            step(0, 1, 1, 0, 0);
         end else begin
            v = (accepts == 0) ? 1'b1 : bit'($urandom_range(1));
            step(0, 1, v, v ? ((accepts == 0) ? 127 : 0) : int'($urandom), 0);
            if (v) accepts++;
         end
      end
      settle();
      check_seq("stall_ph0", e_ph0);

      // Mid-operation reset then replay.
      step(1, 0, 0, 0, 0);
      step(0, 1, 1, 127, 0);
      for (int i = 0; i < 9; i++) step(0, 1, 1, 0, 0);
      step(1, 1, 1, $urandom, 0);
      got.delete();
      step(0, 1, 1, 127, 0);
      for (int i = 0; i < 27; i++) step(0, 1, 1, 0, 0);
      settle();
      check_seq("replay_ph0", e_ph0);

      // Random traffic with occasional phase changes and resets.
      ph = 0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(49) == 0) ph = $urandom_range(3);
         step($urandom_range(99) == 0, $urandom_range(9) != 0,
              $urandom_range(9) < 7, $urandom, ph);
      end
      settle();
      chk_on = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/poly_fir_rx_decimator.md
Name: poly_fir_rx_decimator

Overview:
- Receive-side counterpart of the 4-phase polyphase transmit shaping filter.
- Accepts signed samples at 4x symbol rate and applies the same 24-tap matched filter.
- Decimates by 4 at a programmable sampling phase.
- Emits one filtered soft sample plus a hard bit decision per symbol. Sits between the channel/ADC model and the BER checker.

Parameters:
- NB_INPUT, 8, total bits of input sample, signed S(NB_INPUT,NBF_INPUT).
- NBF_INPUT, 7, fractional bits of input sample.
- NB_COEFF, 8, total bits of coefficients.
- NBF_COEFF, 7, fractional bits of coefficients.
- NB_OUTPUT, 8, total bits of soft output.
- NBF_OUTPUT, 7, fractional bits of soft output.

Ports:
- clk  input  1  system clock.
- i_rst  input  1  reset, synchronous, active-high.
- i_en  input  1  global enable; 0 freezes all state.
- i_valid  input  1  input sample qualifier; a sample is accepted on a clk edge with i_en=1 and i_valid=1.
- i_data  input  NB_INPUT  signed input sample at 4x rate.
- i_phase  input  2  decimation phase select, 0..3.
- o_data  output  NB_OUTPUT  signed filtered, decimated sample.
- o_bit  output  1  hard decision; 1 when filtered sum < 0, matching TX mapping bit 1 -> negative.
- o_valid  output  1  one-cycle strobe qualifying o_data/o_bit.

Behaviour:
- Coefficients, integer Q(8,7), tap 0..23, fixed:
  - 0, 2, 2, 0, -8, -16, -16, -1,
  - 33, 76, 113, 127, 113, 76, 33, 0,
  - -16, -16, -8, -1, 2, 2, 0, 0.
- Delay line: x[0..22], 23 registers of NB_INPUT bits.
  - On accept: x[0] <= i_data, x[k] <= x[k-1].
  - Tap 0 of the filter is i_data itself; tap k (k>=1) is x[k-1].
- Phase counter, 2 bits: increments on every accept and wraps 3 -> 0. It does not change without an accept.
- Arithmetic:
  - Each product is full precision, NB_INPUT+NB_COEFF bits, frac NBF_INPUT+NBF_COEFF.
  - Accumulator is NB_INPUT+NB_COEFF+5 bits (21 at defaults, frac 14); it never overflows.
- Output quantisation:
  - Drop (NBF_INPUT+NBF_COEFF-NBF_OUTPUT) LSBs by truncation (floor).
  - Saturate the integer part to the NB_OUTPUT range: max 2^(NB_OUTPUT-1)-1, min -2^(NB_OUTPUT-1).
  - Defaults: sum>>>7, clamp to [-128, 127].
- Decimation:
  - On an accept edge where the counter value before increment == i_phase, register the quantised sum into o_data.
  - On the same edge, register the sum sign into o_bit and set o_valid=1.
  - Every other edge: o_valid=0, o_data/o_bit hold.
- Latency: o_valid is high in the cycle following the accept edge of the decision sample. Rate is exactly one o_valid per 4 accepts.
- i_phase is sampled at each accept. A mid-stream change takes effect at the next matching count, which may skip or double one symbol; no other side effect.
- i_en=0: delay line, counter, o_data and o_bit hold; o_valid=0 on the next edge. i_valid is ignored.
- i_valid=0 with i_en=1: no shift, no count, o_valid=0.
- Reset, any time including mid-symbol: delay line=0, counter=0, o_data=0, o_bit=0, o_valid=0 from the edge after i_rst is sampled high. i_rst has priority over i_en/i_valid.

Test Plan:
1. Reset: drive random inputs, assert i_rst 2 cycles -> o_data=0, o_bit=0, o_valid=0; after release, first o_valid only after the first matching accept.
2. Impulse, phase 0, i_valid=1 every cycle, counter=0 at the impulse:
   - Stimulus: one sample 127 then zeros.
   - Response: o_data sequence 0, -8, 32, 112, -16, 1, 0…
   - o_bit = 0, 1, 0, 0, 1, 0, 0.
3. Same impulse, i_phase=2 -> o_data sequence 1, -16, 112, 32, -8, 0; o_valid 2 cycles later than each corresponding phase-0 strobe.
4. Saturation:
   - Constant input 127 -> o_data=127, o_bit=0 (sum 493 before clamp).
   - Constant input -128 -> o_data=-128, o_bit=1.
5. Stalls: i_valid toggling 1/0, plus an i_en=0 burst of 5 cycles mid-symbol -> outputs identical to the gap-free run of test 2; o_valid exactly once per 4 accepts; o_data held during the freeze.
6. Mid-operation reset: assert i_rst after 10 samples of test 2 -> state cleared; replaying the impulse reproduces test 2 exactly.
